mux2_rr_feeder: RTL and testbench

//   Upstream stage of the 2:1 mux. Two valid/ready requesters (A, B) compete for one output slot.

---
 rtl/mux2_rr_feeder.sv | 72 +++++++
 tb/tb_mux2_rr_feeder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_feeder.sv
`default_nettype none
// ============================================================================
// Module      : mux2_rr_feeder
// Description : Two-requester round-robin arbiter feeding a one-entry output
//               register. The registered sel records which requester supplied
//               the held word, for the downstream 2:1 mux.
// Revision    : 1.0 - initial release
// ============================================================================
module mux2_rr_feeder #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          sel,
    input  logic          out_ready
);

    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic          r_sel;
    logic          r_last;     // 1: B won most recently, so A has priority

    logic          w_load_en;
    logic          w_grant_a;
    logic          w_grant_b;

    // Load when the slot is empty or being drained; arbitrate on current requests.
    always_comb begin
        w_load_en = ~r_out_valid | out_ready;
        w_grant_a = a_valid & (~b_valid | r_last);
        w_grant_b = b_valid & (~a_valid | ~r_last);
    end

    // Readies are forced low while reset is asserted so nothing is handshaken.
    always_comb begin
        a_ready = rst_n & w_load_en & w_grant_a;
        b_ready = rst_n & w_load_en & w_grant_b;
    end

    // Output register and priority memory; priority only rotates on a real grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sel       <= 1'b0;
            r_last      <= 1'b1;
        end else if (w_load_en) begin
            if (w_grant_a | w_grant_b) begin
                r_out_data  <= w_grant_b ? b_data : a_data;
                r_sel       <= w_grant_b;
                r_last      <= w_grant_b;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign sel       = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_mux2_rr_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux2_rr_feeder
// Description : Directed self-checking bench for mux2_rr_feeder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux2_rr_feeder;

    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          a_valid;
    logic [DW-1:0] a_data;
    logic          a_ready;
    logic          b_valid;
    logic [DW-1:0] b_data;
    logic          b_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          sel;
    logic          out_ready;

    int n_checks;
    int n_fail;

    mux2_rr_feeder #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Short reset pulse applied between edges, requesters idle.
    task automatic do_reset();
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_valid = 1'b1; a_data = 8'h3C;
        b_valid = 1'b1; b_data = 8'hC3;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_checks++; if (sel !== 1'b0) begin n_fail++; $display("FAIL reset_sel got %b exp 0", sel); end
        n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h exp 00", out_data); end
        n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_ready got %b exp 0", a_ready); end
        n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_ready got %b exp 0", b_ready); end
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_source();
        logic [DW-1:0] exp;
        for (int i = 0; i < 3; i++) begin
            exp = 8'(8'h11 * (i + 1));
            @(negedge clk);
            a_valid = 1'b1; a_data = exp; b_valid = 1'b0; out_ready = 1'b1;
            #1;
            n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL single_a_ready[%0d] got %b exp 1", i, a_ready); end
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b1 || out_data !== exp || sel !== 1'b0) begin
                n_fail++; $display("FAIL single_out[%0d] got v=%b d=%h s=%b exp v=1 d=%h s=0", i, out_valid, out_data, sel, exp);
            end
        end
        @(negedge clk);
        a_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h33) begin
            n_fail++; $display("FAIL single_drain got v=%b d=%h exp v=0 d=33", out_valid, out_data);
        end
    endtask

    task automatic test_contention();
        int a_idx;
        int b_idx;
        logic exp_b;
        logic [DW-1:0] exp_d;
        do_reset();
        a_idx = 0; b_idx = 0;
        for (int k = 0; k < 4; k++) begin
            exp_b = (k % 2) == 1;
            @(negedge clk);
            a_valid = 1'b1; a_data = 8'(8'hA0 + a_idx);
            b_valid = 1'b1; b_data = 8'(8'hB0 + b_idx);
            out_ready = 1'b1;
            #1;
            n_checks++; if (a_ready !== !exp_b || b_ready !== exp_b) begin
                n_fail++; $display("FAIL contention_ready[%0d] got a=%b b=%b exp a=%b b=%b", k, a_ready, b_ready, !exp_b, exp_b);
            end
            exp_d = exp_b ? 8'(8'hB0 + b_idx) : 8'(8'hA0 + a_idx);
            @(posedge clk); #1;
            n_checks++; if (sel !== exp_b || out_data !== exp_d || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL contention_out[%0d] got s=%b d=%h v=%b exp s=%b d=%h v=1", k, sel, out_data, out_valid, exp_b, exp_d);
            end
            if (exp_b) b_idx++; else a_idx++;
        end
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_back_pressure();
        // Last grant above was B, so load 0x5A via A alone, then contend.
        @(negedge clk);
        a_valid = 1'b1; a_data = 8'h5A; b_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_data !== 8'h5A || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_load got d=%h v=%b exp d=5a v=1", out_data, out_valid);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            a_valid = 1'b1; a_data = 8'h66; b_valid = 1'b1; b_data = 8'h77; out_ready = 1'b0;
            #1;
            n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_ready[%0d] got a=%b b=%b exp 0 0", c, a_ready, b_ready);
            end
            @(posedge clk); #1;
            n_checks++; if (out_data !== 8'h5A || sel !== 1'b0 || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold[%0d] got d=%h s=%b v=%b exp d=5a s=0 v=1", c, out_data, sel, out_valid);
            end
        end
        // A won last, so B takes the slot once the consumer is ready again.
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_resume_ready got a=%b b=%b exp a=0 b=1", a_ready, b_ready);
        end
        @(posedge clk); #1;
        n_checks++; if (out_data !== 8'h77 || sel !== 1'b1) begin
            n_fail++; $display("FAIL bp_resume_out got d=%h s=%b exp d=77 s=1", out_data, sel);
        end
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_priority_memory();
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b1; b_data = 8'hC3; out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (sel !== 1'b1 || out_data !== 8'hC3) begin
            n_fail++; $display("FAIL prio_b_grant got s=%b d=%h exp s=1 d=c3", sel, out_data);
        end
        @(negedge clk);
        b_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL prio_idle got v=%b exp 0", out_valid);
        end
        @(negedge clk);
        a_valid = 1'b1; a_data = 8'hD1; b_valid = 1'b1; b_data = 8'hE2;
        #1;
        n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_fail++; $display("FAIL prio_ready got a=%b b=%b exp a=1 b=0", a_ready, b_ready);
        end
        @(posedge clk); #1;
        n_checks++; if (sel !== 1'b0 || out_data !== 8'hD1) begin
            n_fail++; $display("FAIL prio_a_grant got s=%b d=%h exp s=0 d=d1", sel, out_data);
        end
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_async_reset();
        // A granted last, so without reset B would win the next contention.
        @(negedge clk);
        a_valid = 1'b1; a_data = 8'h99; b_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #2;
        a_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h99) begin
            n_fail++; $display("FAIL areset_full got v=%b d=%h exp v=1 d=99", out_valid, out_data);
        end
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || sel !== 1'b0) begin
            n_fail++; $display("FAIL areset_drop got v=%b d=%h s=%b exp v=0 d=00 s=0", out_valid, out_data, sel);
        end
        @(negedge clk);
        a_valid = 1'b1; a_data = 8'hAB; b_valid = 1'b1; b_data = 8'hBA; out_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_fail++; $display("FAIL areset_ready got a=%b b=%b exp a=1 b=0", a_ready, b_ready);
        end
        @(posedge clk); #1;
        n_checks++; if (sel !== 1'b0 || out_data !== 8'hAB || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL areset_grant got s=%b d=%h v=%b exp s=0 d=ab v=1", sel, out_data, out_valid);
        end
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        a_valid = 1'b0; b_valid = 1'b0;
        a_data = '0; b_data = '0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_single_source();
        test_contention();
        test_back_pressure();
        test_priority_memory();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
